memory_io_ctrl: RTL and testbench

//  Memory/IO stage driven by the control store's MIO.EN and R.W. Produces the R (ready) bit consumed by the

---
 rtl/memory_io_ctrl_if.sv | 20 ++
 rtl/memory_io_ctrl.sv | 175 +++++++++++++++++
 tb/tb_memory_io_ctrl.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_io_ctrl_if.sv
// Control-store side of the memory/IO stage: access request, address/data and
// the R completion bit with read data returned to the MDR mux.
interface memory_io_ctrl_if;
   logic        i_MIO_EN;
   logic        i_R_W;
   logic [15:0] i_MAR;
   logic [15:0] i_MDR;
   logic        o_R_Bit;
   logic [15:0] o_MemData;

   modport master (
      output i_MIO_EN, i_R_W, i_MAR, i_MDR,
      input  o_R_Bit, o_MemData
   );

   modport slave (
      input  i_MIO_EN, i_R_W, i_MAR, i_MDR,
      output o_R_Bit, o_MemData
   );
endinterface

// File: rtl/memory_io_ctrl.sv
// Memory/IO stage: wait-stated external RAM accesses, memory-mapped keyboard and
// display registers, and keyboard/display interrupt requests.
module memory_io_ctrl #(
   parameter int          WAIT_CYCLES = 2,
   parameter logic [15:0] KBSR_ADDR   = 16'hFE00
) (
   input  logic                    i_CLK,
   input  logic                    i_Reset,
   memory_io_ctrl_if.slave         cpu,
   output logic [15:0]             o_Mem_Addr,
   output logic                    o_Mem_WE,
   output logic [15:0]             o_Mem_WData,
   input  logic [15:0]             i_Mem_RData,
   input  logic                    i_KB_Valid,
   input  logic [7:0]              i_KB_Data,
   output logic                    o_DDR_Valid,
   output logic [7:0]              o_DDR_Data,
   input  logic                    i_DISP_Ready,
   output logic                    o_INT_KB,
   output logic                    o_INT_DSP
);

   localparam logic [15:0] DDR_ADDR = KBSR_ADDR + 16'd6;
   localparam logic [3:0]  CNT_LOAD = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

   state_t      state_reg;
   logic [3:0]  cnt_reg;
   logic        r_bit_reg;
   logic [15:0] mem_data_reg;

   logic        kb_ready_reg;
   logic        kb_ie_reg;
   logic [7:0]  kbdr_reg;
   logic        dsr_ie_reg;
   logic        ddr_valid_reg;
   logic [7:0]  ddr_data_reg;
   logic        int_kb_reg;
   logic        int_dsp_reg;

   logic [3:0]  dev_hit;
   logic        dev_space;
   logic        ram_sel;
   logic        complete;
   logic        rd_done;
   logic        wr_done;
   logic        kbdr_rd;
   logic        kb_accept;
   logic        ddr_accept;
   logic [15:0] dev_rdata;

   // dev_hit[0..3] = KBSR, KBDR, DSR, DDR
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_dev_decode
         assign dev_hit[gi] = (cpu.i_MAR == KBSR_ADDR + 16'(2 * gi));
      end
   endgenerate

   assign dev_space   = (cpu.i_MAR >= KBSR_ADDR) && (cpu.i_MAR <= DDR_ADDR);
   assign ram_sel     = ~dev_space;
   assign o_Mem_Addr  = cpu.i_MAR;
   assign o_Mem_WData = cpu.i_MDR;

   // The access commits only on the last wait cycle, and only if MIO.EN is still held.
   assign complete = (state_reg == ST_WAIT) && (cnt_reg == 4'd1) && cpu.i_MIO_EN;
   assign rd_done  = complete && !cpu.i_R_W;
   assign wr_done  = complete && cpu.i_R_W;
   assign o_Mem_WE = wr_done && ram_sel;

   assign kbdr_rd    = rd_done && dev_hit[1];
   assign kb_accept  = i_KB_Valid && (!kb_ready_reg || kbdr_rd);
   assign ddr_accept = wr_done && dev_hit[3] && (!ddr_valid_reg || i_DISP_Ready);

   always_comb begin
      dev_rdata = 16'h0000;
      if (dev_hit[0]) begin
         dev_rdata = {kb_ready_reg, kb_ie_reg, 14'b0};
      end else if (dev_hit[1]) begin
         dev_rdata = {8'b0, kbdr_reg};
      end else if (dev_hit[2]) begin
         dev_rdata = {~ddr_valid_reg, dsr_ie_reg, 14'b0};
      end
   end

   always_ff @(posedge i_CLK or negedge i_Reset) begin
      if (!i_Reset) begin
         state_reg    <= ST_IDLE;
         cnt_reg      <= 4'd0;
         r_bit_reg    <= 1'b0;
         mem_data_reg <= 16'h0000;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               r_bit_reg <= 1'b0;
               if (cpu.i_MIO_EN) begin
                  state_reg <= ST_WAIT;
                  cnt_reg   <= CNT_LOAD;
               end
            end
            ST_WAIT: begin
               if (!cpu.i_MIO_EN) begin
                  state_reg <= ST_IDLE;
                  cnt_reg   <= 4'd0;
               end else if (cnt_reg == 4'd1) begin
                  state_reg <= ST_DONE;
                  cnt_reg   <= 4'd0;
                  r_bit_reg <= 1'b1;
               end else begin
                  cnt_reg <= cnt_reg - 4'd1;
               end
            end
            ST_DONE: begin
               r_bit_reg <= 1'b0;
               state_reg <= ST_IDLE;
            end
            default: begin
               r_bit_reg <= 1'b0;
               state_reg <= ST_IDLE;
               cnt_reg   <= 4'd0;
            end
         endcase
         if (rd_done) begin
            mem_data_reg <= ram_sel ? i_Mem_RData : dev_rdata;
         end
      end
   end

   always_ff @(posedge i_CLK or negedge i_Reset) begin
      if (!i_Reset) begin
         kb_ready_reg  <= 1'b0;
         kb_ie_reg     <= 1'b0;
         kbdr_reg      <= 8'h00;
         dsr_ie_reg    <= 1'b0;
         ddr_valid_reg <= 1'b0;
         ddr_data_reg  <= 8'h00;
         int_kb_reg    <= 1'b0;
         int_dsp_reg   <= 1'b0;
      end else begin
         // A key landing on the same edge as a KBDR read replaces the byte being consumed.
         if (kb_accept) begin
            kbdr_reg     <= i_KB_Data;
            kb_ready_reg <= 1'b1;
         end else if (kbdr_rd) begin
            kb_ready_reg <= 1'b0;
         end

         if (wr_done && dev_hit[0]) begin
            kb_ie_reg <= cpu.i_MDR[14];
         end
         if (wr_done && dev_hit[2]) begin
            dsr_ie_reg <= cpu.i_MDR[14];
         end

         if (ddr_accept) begin
            ddr_data_reg  <= cpu.i_MDR[7:0];
            ddr_valid_reg <= 1'b1;
         end else if (i_DISP_Ready) begin
            ddr_valid_reg <= 1'b0;
         end

         int_kb_reg  <= kb_ready_reg & kb_ie_reg;
         int_dsp_reg <= ~ddr_valid_reg & dsr_ie_reg;
      end
   end

   assign cpu.o_R_Bit   = r_bit_reg;
   assign cpu.o_MemData = mem_data_reg;
   assign o_DDR_Valid   = ddr_valid_reg;
   assign o_DDR_Data    = ddr_data_reg;
   assign o_INT_KB      = int_kb_reg;
   assign o_INT_DSP     = int_dsp_reg;

endmodule

// File: tb/tb_memory_io_ctrl.sv
// Bench for memory_io_ctrl: RAM model, scoreboard of expected read data and a
// small register model of the keyboard/display devices.
module tb_memory_io_ctrl;
   localparam int          WAIT_CYCLES = 2;
   localparam logic [15:0] KBSR = 16'hFE00;
   localparam logic [15:0] KBDR = 16'hFE02;
   localparam logic [15:0] DSR  = 16'hFE04;
   localparam logic [15:0] DDR  = 16'hFE06;

   logic        i_CLK = 1'b0;
   logic        i_Reset = 1'b0;
   logic [15:0] o_Mem_Addr;
   logic        o_Mem_WE;
   logic [15:0] o_Mem_WData;
   logic [15:0] ram_rdata;
   logic        i_KB_Valid = 1'b0;
   logic [7:0]  i_KB_Data = 8'h00;
   logic        o_DDR_Valid;
   logic [7:0]  o_DDR_Data;
   logic        i_DISP_Ready = 1'b0;
   logic        o_INT_KB;
   logic        o_INT_DSP;

   memory_io_ctrl_if bus_if();

   memory_io_ctrl #(.WAIT_CYCLES(WAIT_CYCLES), .KBSR_ADDR(KBSR)) dut (
      .i_CLK        (i_CLK),
      .i_Reset      (i_Reset),
      .cpu          (bus_if),
      .o_Mem_Addr   (o_Mem_Addr),
      .o_Mem_WE     (o_Mem_WE),
      .o_Mem_WData  (o_Mem_WData),
      .i_Mem_RData  (ram_rdata),
      .i_KB_Valid   (i_KB_Valid),
      .i_KB_Data    (i_KB_Data),
      .o_DDR_Valid  (o_DDR_Valid),
      .o_DDR_Data   (o_DDR_Data),
      .i_DISP_Ready (i_DISP_Ready),
      .o_INT_KB     (o_INT_KB),
      .o_INT_DSP    (o_INT_DSP)
   );

   always #5 i_CLK = ~i_CLK;

   // External synchronous RAM, one cycle read latency
   logic [15:0] ram_mem [0:65535];
   always @(posedge i_CLK) begin
      if (o_Mem_WE) ram_mem[o_Mem_Addr] <= o_Mem_WData;
      ram_rdata <= ram_mem[o_Mem_Addr];
   end

   int checks = 0;
   int failures = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference model
   logic [15:0] shadow [logic [15:0]];
   logic        m_kb_ready = 1'b0;
   logic        m_kb_ie = 1'b0;
   logic [7:0]  m_kbdr = 8'h00;
   logic        m_dsr_ie = 1'b0;
   logic        m_ddr_valid = 1'b0;
   logic [7:0]  m_ddr_data = 8'h00;
   logic [15:0] exp_q [$];

   function automatic logic is_ram(input logic [15:0] a);
      return !((a >= KBSR) && (a <= DDR));
   endfunction

   function automatic logic [15:0] model_read(input logic [15:0] a);
      if (a == KBSR) return {m_kb_ready, m_kb_ie, 14'b0};
      if (a == KBDR) return {8'b0, m_kbdr};
      if (a == DSR)  return {~m_ddr_valid, m_dsr_ie, 14'b0};
      if (!is_ram(a)) return 16'h0000;
      if (shadow.exists(a)) return shadow[a];
      return 16'hxxxx;
   endfunction

   task automatic model_reset();
      m_kb_ready = 1'b0; m_kb_ie = 1'b0; m_kbdr = 8'h00;
      m_dsr_ie = 1'b0; m_ddr_valid = 1'b0; m_ddr_data = 8'h00;
   endtask

   task automatic mem_access(input logic rw, input logic [15:0] addr, input logic [15:0] data);
      int c;
      int we_cnt;
      int we_cyc;
      bit got_r;
      logic [15:0] exp;
      if (!rw) exp_q.push_back(model_read(addr));
      @(negedge i_CLK);
      bus_if.i_MIO_EN = 1'b1;
      bus_if.i_R_W    = rw;
      bus_if.i_MAR    = addr;
      bus_if.i_MDR    = data;
      c = 0; we_cnt = 0; we_cyc = -1; got_r = 1'b0;
      while (c < 20 && !got_r) begin
         #1;
         if (o_Mem_WE) begin
            we_cnt++;
            we_cyc = c;
            check_val("we_addr", o_Mem_Addr, addr);
            check_val("we_data", o_Mem_WData, data);
         end
         if (bus_if.o_R_Bit) got_r = 1'b1;
         else begin
            @(negedge i_CLK);
            c++;
         end
      end
      bus_if.i_MIO_EN = 1'b0;
      check_val("r_latency", got_r ? c : 99, WAIT_CYCLES + 1);
      check_val("we_count", we_cnt, (rw && is_ram(addr)) ? 1 : 0);
      if (rw && is_ram(addr)) check_val("we_cycle", we_cyc, WAIT_CYCLES);
      if (rw) begin
         if (is_ram(addr)) shadow[addr] = data;
         if (addr == KBSR) m_kb_ie = data[14];
         if (addr == DSR)  m_dsr_ie = data[14];
         if (addr == DDR && !m_ddr_valid) begin
            m_ddr_valid = 1'b1;
            m_ddr_data  = data[7:0];
         end
      end else begin
         exp = exp_q.pop_front();
         check_val("rd_data", bus_if.o_MemData, exp);
         if (addr == KBDR) m_kb_ready = 1'b0;
      end
      @(negedge i_CLK);
      #1;
      check_val("r_one_cycle", bus_if.o_R_Bit, 1'b0);
      $display("access %s addr=0x%04h data=0x%04h memdata=0x%04h r_cycle=%0d we_pulses=%0d",
               rw ? "WR" : "RD", addr, data, bus_if.o_MemData, c, we_cnt);
   endtask

   task automatic send_key(input logic [7:0] k);
      @(negedge i_CLK);
      i_KB_Valid = 1'b1;
      i_KB_Data  = k;
      @(negedge i_CLK);
      i_KB_Valid = 1'b0;
      if (!m_kb_ready) begin
         m_kb_ready = 1'b1;
         m_kbdr     = k;
      end
      $display("key 0x%02h offered, kbdr_model=0x%02h", k, m_kbdr);
   endtask

   task automatic check_ddr(input string tag);
      check_val({tag, "_valid"}, o_DDR_Valid, m_ddr_valid);
      check_val({tag, "_data"}, o_DDR_Data, m_ddr_data);
   endtask

   initial begin
      int we_seen;
      int r_seen;
      bus_if.i_MIO_EN = 1'b0;
      bus_if.i_R_W    = 1'b0;
      bus_if.i_MAR    = 16'h0000;
      bus_if.i_MDR    = 16'h0000;

      repeat (3) @(negedge i_CLK);
      #1;
      check_val("rst_r", bus_if.o_R_Bit, 1'b0);
      check_val("rst_memdata", bus_if.o_MemData, 16'h0000);
      check_val("rst_we", o_Mem_WE, 1'b0);
      check_val("rst_ddr_valid", o_DDR_Valid, 1'b0);
      check_val("rst_ddr_data", o_DDR_Data, 8'h00);
      check_val("rst_int_kb", o_INT_KB, 1'b0);
      check_val("rst_int_dsp", o_INT_DSP, 1'b0);
      @(negedge i_CLK);
      i_Reset = 1'b1;

      // RAM path
      mem_access(1'b1, 16'h3000, 16'hBEEF);
      mem_access(1'b1, 16'h3001, 16'h1234);
      mem_access(1'b0, 16'h3000, 16'h0000);
      mem_access(1'b0, 16'h3001, 16'h0000);
      mem_access(1'b0, DSR, 16'h0000);
      mem_access(1'b0, KBSR, 16'h0000);

      // Keyboard: second key dropped while first pending
      send_key(8'h41);
      send_key(8'h42);
      mem_access(1'b0, KBSR, 16'h0000);
      mem_access(1'b0, KBDR, 16'h0000);
      mem_access(1'b0, KBSR, 16'h0000);

      // Keyboard interrupt
      mem_access(1'b1, KBSR, 16'h4000);
      mem_access(1'b0, KBSR, 16'h0000);
      @(negedge i_CLK);
      i_KB_Valid = 1'b1;
      i_KB_Data  = 8'h43;
      @(negedge i_CLK);
      i_KB_Valid = 1'b0;
      m_kb_ready = 1'b1;
      m_kbdr     = 8'h43;
      #1;
      check_val("int_kb_lag", o_INT_KB, 1'b0);
      @(negedge i_CLK);
      #1;
      check_val("int_kb_set", o_INT_KB, 1'b1);
      mem_access(1'b0, KBDR, 16'h0000);
      check_val("int_kb_clear", o_INT_KB, 1'b0);

      // Display: second character dropped while one is pending
      mem_access(1'b1, DDR, 16'h0058);
      check_ddr("ddr_first");
      mem_access(1'b1, DDR, 16'h0059);
      check_ddr("ddr_second");
      mem_access(1'b0, DSR, 16'h0000);
      @(negedge i_CLK);
      i_DISP_Ready = 1'b1;
      @(negedge i_CLK);
      i_DISP_Ready = 1'b0;
      m_ddr_valid = 1'b0;
      #1;
      check_ddr("ddr_drained");
      mem_access(1'b0, DSR, 16'h0000);
      mem_access(1'b1, DSR, 16'h4000);
      check_val("int_dsp_set", o_INT_DSP, 1'b1);
      mem_access(1'b0, DSR, 16'h0000);

      // Abort mid-WAIT on a write
      mem_access(1'b1, 16'h3002, 16'h1111);
      @(negedge i_CLK);
      bus_if.i_MIO_EN = 1'b1;
      bus_if.i_R_W    = 1'b1;
      bus_if.i_MAR    = 16'h3002;
      bus_if.i_MDR    = 16'h5555;
      we_seen = 0;
      r_seen  = 0;
      for (int k = 0; k < 6; k++) begin
         #1;
         if (o_Mem_WE) we_seen++;
         if (bus_if.o_R_Bit) r_seen++;
         @(negedge i_CLK);
         if (k == 0) bus_if.i_MIO_EN = 1'b0;
      end
      check_val("abort_we", we_seen, 0);
      check_val("abort_r", r_seen, 0);
      $display("abort write addr=0x3002 data=0x5555 we_pulses=%0d r_pulses=%0d", we_seen, r_seen);
      mem_access(1'b0, 16'h3002, 16'h0000);

      // Reset in the middle of an access with device state pending
      mem_access(1'b1, DDR, 16'h005A);
      send_key(8'h44);
      @(negedge i_CLK);
      #1;
      check_val("pre_rst_int_kb", o_INT_KB, 1'b1);
      check_ddr("pre_rst_ddr");
      @(negedge i_CLK);
      bus_if.i_MIO_EN = 1'b1;
      bus_if.i_R_W    = 1'b1;
      bus_if.i_MAR    = 16'h3003;
      bus_if.i_MDR    = 16'h7777;
      @(negedge i_CLK);
      i_Reset = 1'b0;
      #1;
      check_val("mid_rst_r", bus_if.o_R_Bit, 1'b0);
      check_val("mid_rst_memdata", bus_if.o_MemData, 16'h0000);
      check_val("mid_rst_we", o_Mem_WE, 1'b0);
      check_val("mid_rst_ddr_valid", o_DDR_Valid, 1'b0);
      check_val("mid_rst_ddr_data", o_DDR_Data, 8'h00);
      check_val("mid_rst_int_kb", o_INT_KB, 1'b0);
      check_val("mid_rst_int_dsp", o_INT_DSP, 1'b0);
      $display("reset asserted mid-access addr=0x3003");
      bus_if.i_MIO_EN = 1'b0;
      model_reset();
      @(negedge i_CLK);
      i_Reset = 1'b1;
      mem_access(1'b0, DSR, 16'h0000);
      mem_access(1'b0, KBSR, 16'h0000);
      mem_access(1'b0, KBDR, 16'h0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end
endmodule
